// File: rtl/clken_switch_div.sv
// CPU clock generator: programmable divide of hsclk_in (HS) or retimed lsclk_in (LS), with glitch-free switching.
// Latency: LS mode follows lsclk_in after SYNC_STAGES+1 cycles; status outputs change on the same edge as the state.
// No backpressure: free-running, hsclk_sel is sampled every cycle, callers poll hsclk_selected/lsclk_selected.
module clken_switch_div #(
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             hsclk_in,
    input  logic             rst,
    input  logic             lsclk_in,
    input  logic             hsclk_sel,
    input  logic [DIV_W-1:0] div_val,
    output logic             cpuclk_q,
    output logic             cpuclk_rise_q,
    output logic             cpuclk_fall_q,
    output logic             hsclk_selected,
    output logic             lsclk_selected,
    output logic             switch_busy
);

    typedef enum logic [1:0] {
        LS_RUN = 2'd0,
        TO_HS  = 2'd1,
        HS_RUN = 2'd2,
        TO_LS  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ls_s;
    logic                   ls_d_q;
    logic                   ls_fall;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    // div_q is captured from div_val on each 1->0 edge; div_cur_q is the compare
    // value actually used in HS_RUN and only takes div_q on the 0->1 edge, so a
    // high phase and the low phase after it always share one half-period length.
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       div_cur_q, div_cur_d;
    logic                   cpuclk_d;

    assign ls_s    = sync_q[SYNC_STAGES-1];
    assign ls_fall = ls_d_q & ~ls_s;

    // Synchronise the async slow reference and keep one extra stage for fall detection.
    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            ls_d_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lsclk_in};
            ls_d_q <= ls_s;
        end
    end

    // Next-state, counter and clock-level decisions; state transitions take priority over counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        div_cur_d = div_cur_q;
        cpuclk_d  = cpuclk_q;
        case (state_q)
            LS_RUN: begin
                cpuclk_d = ls_s;
                if (ls_fall && hsclk_sel) begin
                    state_d  = TO_HS;
                    cnt_d    = '0;
                    div_d    = div_val;
                    cpuclk_d = 1'b0;
                end
            end
            TO_HS: begin
                cpuclk_d = 1'b0;
                if (!hsclk_sel) begin
                    state_d = TO_LS;
                end else if (cnt_q == div_q) begin
                    state_d   = HS_RUN;
                    cpuclk_d  = 1'b1;
                    cnt_d     = '0;
                    div_cur_d = div_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HS_RUN: begin
                if (cnt_q == div_cur_q) begin
                    cnt_d    = '0;
                    cpuclk_d = ~cpuclk_q;
                    if (cpuclk_q) begin
                        // End of a high phase: the only point where leaving HS is safe.
                        div_d = div_val;
                        if (!hsclk_sel) begin
                            state_d = TO_LS;
                        end
                    end else begin
                        div_cur_d = div_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TO_LS: begin
                cpuclk_d = 1'b0;
                if (hsclk_sel) begin
                    state_d = TO_HS;
                    cnt_d   = '0;
                    div_d   = div_val;
                end else if (ls_fall) begin
                    // Joining on an LS fall guarantees the next LS high phase is full length.
                    state_d  = LS_RUN;
                    cpuclk_d = ls_s;
                end
            end
            default: begin
                state_d  = LS_RUN;
                cpuclk_d = 1'b0;
            end
        endcase
    end

    // State, counters, clock level, edge pulses and status decodes all register together.
    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            state_q        <= LS_RUN;
            cnt_q          <= '0;
            div_q          <= '0;
            div_cur_q      <= '0;
            cpuclk_q       <= 1'b0;
            cpuclk_rise_q  <= 1'b0;
            cpuclk_fall_q  <= 1'b0;
            hsclk_selected <= 1'b0;
            lsclk_selected <= 1'b1;
            switch_busy    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            div_cur_q      <= div_cur_d;
            cpuclk_q       <= cpuclk_d;
            cpuclk_rise_q  <= cpuclk_d & ~cpuclk_q;
            cpuclk_fall_q  <= ~cpuclk_d & cpuclk_q;
            hsclk_selected <= (state_d == HS_RUN);
            lsclk_selected <= (state_d == LS_RUN);
            switch_busy    <= (state_d == TO_HS) || (state_d == TO_LS);
        end
    end

endmodule
